// File: rtl/seq1101_detector_pkg.sv
// rtl/seq1101_detector_pkg.sv - shared state encoding, pattern constant and transition function
package seq1101_detector_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1101;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    // S4 on a '1' falls back to S2: the match's trailing '1' plus the new '1' is "11".
    function automatic state_e next_state(input state_e cur, input logic bit_in);
        case (cur)
            S0:      next_state = (bit_in == PATTERN[3]) ? S1 : S0;
            S1:      next_state = (bit_in == PATTERN[2]) ? S2 : S0;
            S2:      next_state = (bit_in == PATTERN[1]) ? S3 : S2;
            S3:      next_state = (bit_in == PATTERN[0]) ? S4 : S0;
            S4:      next_state = bit_in ? S2 : S0;
            default: next_state = S0;
        endcase
    endfunction

endpackage

// File: rtl/seq1101_detector_sat_counter.sv
// rtl/seq1101_detector_sat_counter.sv - saturating up-counter with sync reset and clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq1101_detector.sv
// rtl/seq1101_detector.sv - overlapping 1101 detector with registered match pulse and saturating count
module seq1101_detector
    import seq1101_detector_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               din,
    input  logic               din_valid,
    output logic               match,
    output logic [COUNT_W-1:0] match_count,
    output logic [STATE_W-1:0] state_o
);

    state_e state_q, state_d;
    logic   match_q;
    logic   legal;
    logic   hit;

    // Illegal encodings recover to S0 even while din_valid is low.
    always_comb begin
        legal = (state_q == S0) || (state_q == S1) || (state_q == S2)
             || (state_q == S3) || (state_q == S4);
        state_d = state_q;
        if (din_valid || !legal) begin
            state_d = next_state(state_q, din);
        end
        hit = din_valid && legal && (state_d == S4);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else if (clear) begin
            state_q <= S0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= hit;
        end
    end

    sat_counter #(.W(COUNT_W)) u_count (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .inc     (hit),
        .count   (match_count)
    );

    assign match   = match_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seq1101_detector.sv
// tb/tb_seq1101_detector.sv - directed and random bench for seq1101_detector against a history-based model
module tb_seq1101_detector;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       match8, match2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic [2:0] state8, state2;

    int errors = 0;
    int checks = 0;

    logic [3:0] m_hist = 4'b0;
    int         m_n = 0;
    int         m_state = 0;
    logic       m_match = 1'b0;
    int         m_cnt8 = 0;
    int         m_cnt2 = 0;

    always #5 clock = ~clock;

    seq1101_detector #(.COUNT_W(8)) dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match8),
        .match_count (cnt8),
        .state_o     (state8)
    );

    seq1101_detector #(.COUNT_W(2)) dut2 (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (clear),
        .din         (din),
        .din_valid   (din_valid),
        .match       (match2),
        .match_count (cnt2),
        .state_o     (state2)
    );

    // Longest suffix of the accepted bits that is a prefix of 1101; 4 means full match.
    function automatic int prefix_len(input logic [3:0] h, input int n);
        logic [3:0] pat;
        logic       ok;
        pat = 4'b1101;
        for (int k = 4; k >= 1; k--) begin
            if (n >= k) begin
                ok = 1'b1;
                for (int i = 0; i < k; i++) begin
                    if (h[k-1-i] !== pat[3-i]) ok = 1'b0;
                end
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic d, input logic v, input logic c, input logic r);
        din = d;
        din_valid = v;
        clear = c;
        reset_n = r;
        @(posedge clock);
        if (!r || c) begin
            m_hist = 4'b0;
            m_n = 0;
            m_state = 0;
            m_match = 1'b0;
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (v) begin
            m_hist = {m_hist[2:0], d};
            if (m_n < 4) m_n++;
            m_state = prefix_len(m_hist, m_n);
            m_match = (m_state == 4);
            if (m_match) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end else begin
            m_match = 1'b0;
        end
        #1;
        check("match8", 32'(match8), 32'(m_match));
        check("match2", 32'(match2), 32'(m_match));
        check("count8", 32'(cnt8), 32'(m_cnt8));
        check("count2", 32'(cnt2), 32'(m_cnt2));
        check("state8", 32'(state8), 32'(m_state));
        check("state2", 32'(state2), 32'(m_state));
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i] == "1", 1'b1, 1'b0, 1'b1);
        end
    endtask

    initial begin
        // reset held with din=1, din_valid=1, then first pattern
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        feed("1101");

        // overlap
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed("1101101");

        // long prefix
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed("111101");

        // valid gaps with toggling din
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed("11");
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        feed("01");

        // saturation of the narrow counter
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed("1101101101101");

        // reset mid-pattern
        feed("110");
        step(1'b1, 1'b1, 1'b0, 1'b0);
        feed("1");

        // clear coincident with completing bit
        step(1'b0, 1'b0, 1'b0, 1'b0);
        feed("110");
        step(1'b1, 1'b1, 1'b1, 1'b1);

        // random traffic, occasional clear and reset
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 60) == 0),
                 1'($urandom_range(0, 90) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
